// File: rtl/servo_pkg.sv
// Shared types and constants for the servo command sequencer.
package servo_pkg;

   typedef enum logic [1:0] {StIdle, StAxis, StValue, StCheck} state_e;

   localparam logic [7:0] SYNC_BYTE   = 8'hFF;
   localparam logic [7:0] CHK_XOR     = 8'hA5;
   localparam logic [7:0] AXIS_X      = 8'h00;
   localparam logic [7:0] AXIS_Y      = 8'h01;
   localparam logic [7:0] AXIS_XY     = 8'h02;
   localparam logic [7:0] DEFAULT_POS = 8'd128;

endpackage

// File: rtl/servo_timeout_ctr.sv
// Inter-byte timeout counter: saturates at TIMEOUT_CYCLES-1 and flags expiry there.
module servo_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic clk50mhz,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk50mhz or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/servo_cmd_sequencer.sv
// Parses SYNC/AXIS/VALUE/CHK packets into pending targets and commits them on frame_start.
module servo_cmd_sequencer #(
   parameter int unsigned CLK_FREQ       = 50000000,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [7:0]  SYNC_BYTE      = servo_pkg::SYNC_BYTE,
   parameter logic [7:0]  DEFAULT_POS    = servo_pkg::DEFAULT_POS
) (
   input  logic       clk50mhz,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       frame_start,
   output logic [7:0] x_target,
   output logic [7:0] y_target,
   output logic       update_pulse,
   output logic       chk_err,
   output logic       timeout_err,
   output logic       busy
);

   import servo_pkg::*;

   if (CLK_FREQ == 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("servo_cmd_sequencer: invalid CLK_FREQ or TIMEOUT_CYCLES");
   end

   state_e     state_q, state_d;
   logic [7:0] axis_q, axis_d, value_q, value_d;
   logic [7:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
   logic       pend_valid_q, pend_valid_d;
   logic [7:0] x_q, x_d, y_q, y_d;
   logic       update_q, update_d, chk_err_q, chk_err_d;
   logic       timeout_err_q, timeout_err_d, busy_q, busy_d;
   logic       expired;

   servo_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk50mhz(clk50mhz),
      .rst     (rst),
      .clear   (rx_valid || (state_q == StIdle)),
      .enable  (state_q != StIdle),
      .expired (expired)
   );

   always_comb begin
      state_d       = state_q;
      axis_d        = axis_q;
      value_d       = value_q;
      pend_x_d      = pend_x_q;
      pend_y_d      = pend_y_q;
      pend_valid_d  = pend_valid_q;
      x_d           = x_q;
      y_d           = y_q;
      update_d      = 1'b0;
      chk_err_d     = 1'b0;
      timeout_err_d = 1'b0;

      // Commit reads the old pending values, so a packet accepted this cycle waits a frame.
      if (frame_start && pend_valid_q) begin
         x_d          = pend_x_q;
         y_d          = pend_y_q;
         update_d     = 1'b1;
         pend_valid_d = 1'b0;
      end

      if (rx_valid) begin
         unique case (state_q)
            StIdle: begin
               if (rx_data == SYNC_BYTE) state_d = StAxis;
            end
            StAxis: begin
               if (rx_data == SYNC_BYTE) begin
                  state_d = StAxis;
               end else if (rx_data <= AXIS_XY) begin
                  axis_d  = rx_data;
                  state_d = StValue;
               end else begin
                  chk_err_d = 1'b1;
                  state_d   = StIdle;
               end
            end
            StValue: begin
               value_d = rx_data;
               state_d = StCheck;
            end
            StCheck: begin
               if (rx_data == (axis_q ^ value_q ^ CHK_XOR)) begin
                  if (axis_q != AXIS_Y) pend_x_d = value_q;
                  if (axis_q != AXIS_X) pend_y_d = value_q;
                  pend_valid_d = 1'b1;
               end else begin
                  chk_err_d = 1'b1;
               end
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end else if (expired) begin
         state_d       = StIdle;
         timeout_err_d = 1'b1;
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk50mhz or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         axis_q        <= '0;
         value_q       <= '0;
         pend_x_q      <= DEFAULT_POS;
         pend_y_q      <= DEFAULT_POS;
         pend_valid_q  <= 1'b0;
         x_q           <= DEFAULT_POS;
         y_q           <= DEFAULT_POS;
         update_q      <= 1'b0;
         chk_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         axis_q        <= axis_d;
         value_q       <= value_d;
         pend_x_q      <= pend_x_d;
         pend_y_q      <= pend_y_d;
         pend_valid_q  <= pend_valid_d;
         x_q           <= x_d;
         y_q           <= y_d;
         update_q      <= update_d;
         chk_err_q     <= chk_err_d;
         timeout_err_q <= timeout_err_d;
         busy_q        <= busy_d;
      end
   end

   assign x_target     = x_q;
   assign y_target     = y_q;
   assign update_pulse = update_q;
   assign chk_err      = chk_err_q;
   assign timeout_err  = timeout_err_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// Directed bench for servo_cmd_sequencer with a commit scoreboard fed by a small packet model.
module tb_servo_cmd_sequencer;

   localparam int unsigned TO = 200;

   logic       clk50mhz = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       frame_start = 1'b0;
   logic [7:0] x_target, y_target;
   logic       update_pulse, chk_err, timeout_err, busy;

   always #10 clk50mhz = ~clk50mhz;

   servo_cmd_sequencer #(
      .CLK_FREQ      (50000000),
      .TIMEOUT_CYCLES(TO),
      .SYNC_BYTE     (8'hFF),
      .DEFAULT_POS   (8'd128)
   ) dut (
      .clk50mhz    (clk50mhz),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .frame_start (frame_start),
      .x_target    (x_target),
      .y_target    (y_target),
      .update_pulse(update_pulse),
      .chk_err     (chk_err),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   typedef struct packed {logic [7:0] x; logic [7:0] y;} tgt_t;
   tgt_t exp_q[$];
   tgt_t mon_e;

   int n_assert = 0;
   int n_fail   = 0;

   // Model of the pending registers and of the committed targets.
   logic [7:0] m_px = 8'h80, m_py = 8'h80, m_x = 8'h80, m_y = 8'h80;
   bit         m_pv = 1'b0;
   logic       chk_seen, to_seen, upd_seen;
   int         k;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk50mhz) begin
      if (!rst && update_pulse === 1'b1) begin
         n_assert++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL spurious_update: observed pulse expected none");
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("commit_x", 32'(x_target), 32'(mon_e.x));
            check("commit_y", 32'(y_target), 32'(mon_e.y));
            m_x = mon_e.x;
            m_y = mon_e.y;
         end
      end
   end

   task automatic model_frame();
      if (m_pv) begin
         exp_q.push_back({m_px, m_py});
         m_pv = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit fs);
      @(negedge clk50mhz);
      rx_data  = b;
      rx_valid = 1'b1;
      frame_start = fs;
      if (fs) model_frame();
      @(negedge clk50mhz);
      rx_valid    = 1'b0;
      frame_start = 1'b0;
      chk_seen = chk_err;
      to_seen  = timeout_err;
      upd_seen = update_pulse;
   endtask

   task automatic send_pkt(input logic [7:0] axis, input logic [7:0] val,
                           input logic [7:0] chk, input bit fs_on_chk);
      bit ok;
      send_byte(8'hFF, 1'b0);
      send_byte(axis, 1'b0);
      if (axis > 8'h02) begin
         check("axis_chk_err", 32'(chk_seen), 32'd1);
      end else begin
         send_byte(val, 1'b0);
         send_byte(chk, fs_on_chk);
         ok = (chk == (axis ^ val ^ 8'hA5));
         if (ok) begin
            if (axis != 8'h01) m_px = val;
            if (axis != 8'h00) m_py = val;
            m_pv = 1'b1;
         end
         check("pkt_chk_err", 32'(chk_seen), 32'(!ok));
      end
      check("pkt_busy_idle", 32'(busy), 32'd0);
   endtask

   task automatic frame();
      bit pv;
      @(negedge clk50mhz);
      frame_start = 1'b1;
      pv = m_pv;
      model_frame();
      @(negedge clk50mhz);
      frame_start = 1'b0;
      check("update_pulse", 32'(update_pulse), 32'(pv));
      @(negedge clk50mhz);
      check("update_pulse_width", 32'(update_pulse), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk50mhz);
      check("rst_x", 32'(x_target), 32'h80);
      check("rst_y", 32'(y_target), 32'h80);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_update", 32'(update_pulse), 32'd0);
      rst = 1'b0;

      // Single X packet then commit.
      send_pkt(8'h00, 8'h40, 8'hE5, 1'b0);
      frame();
      check("x_after_first", 32'(x_target), 32'h40);
      check("y_after_first", 32'(y_target), 32'h80);

      // Both-axes packet stays pending while no frame_start arrives.
      send_pkt(8'h02, 8'h10, 8'hB7, 1'b0);
      repeat (300) @(negedge clk50mhz);
      check("x_held", 32'(x_target), 32'(m_x));
      check("y_held", 32'(y_target), 32'h80);
      frame();
      check("x_both", 32'(x_target), 32'h10);
      check("y_both", 32'(y_target), 32'h10);

      // Bad checksum, then bad axis ID.
      send_pkt(8'h01, 8'h20, 8'h00, 1'b0);
      frame();
      check("y_after_badchk", 32'(y_target), 32'h10);
      send_pkt(8'h07, 8'h00, 8'h00, 1'b0);
      @(negedge clk50mhz);
      check("chk_err_width", 32'(chk_err), 32'd0);

      // Inter-byte timeout after FF 00.
      send_byte(8'hFF, 1'b0);
      send_byte(8'h00, 1'b0);
      k = 0;
      while (k < int'(TO) + 20 && timeout_err !== 1'b1) begin
         @(negedge clk50mhz);
         k++;
      end
      check("timeout_latency", 32'(k), 32'(TO));
      check("timeout_busy", 32'(busy), 32'd0);
      @(negedge clk50mhz);
      check("timeout_width", 32'(timeout_err), 32'd0);
      // Extra SYNC exercises resync in the AXIS state.
      send_byte(8'hFF, 1'b0);
      send_pkt(8'h00, 8'h50, 8'hF5, 1'b0);

      // Y packet whose CHK coincides with frame_start while X=0x50 is pending.
      send_pkt(8'h01, 8'h30, 8'h94, 1'b1);
      check("coinc_update", 32'(upd_seen), 32'd1);
      check("coinc_x", 32'(x_target), 32'h50);
      check("coinc_y", 32'(y_target), 32'h10);
      frame();
      check("later_x", 32'(x_target), 32'h50);
      check("later_y", 32'(y_target), 32'h30);

      // Reset in the middle of a packet.
      send_byte(8'hFF, 1'b0);
      send_byte(8'h00, 1'b0);
      @(negedge clk50mhz);
      rst = 1'b1;
      #1;
      check("mid_rst_x", 32'(x_target), 32'h80);
      check("mid_rst_y", 32'(y_target), 32'h80);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_update", 32'(update_pulse), 32'd0);
      check("mid_rst_chk", 32'(chk_err), 32'd0);
      check("mid_rst_to", 32'(timeout_err), 32'd0);
      m_px = 8'h80; m_py = 8'h80; m_x = 8'h80; m_y = 8'h80; m_pv = 1'b0;
      exp_q.delete();
      @(negedge clk50mhz);
      rst = 1'b0;
      send_pkt(8'h00, 8'h40, 8'hE5, 1'b0);
      frame();
      check("post_rst_x", 32'(x_target), 32'h40);
      check("post_rst_y", 32'(y_target), 32'h80);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
